substitution_layer: RTL and testbench
=====================================

Name: substitution_layer

Overview:
- Ascon permutation substitution layer p_S (NIST SP 800-232 Sec 3.3).
- Applies the 5-bit Ascon S-box to each of the 64 bit-slices of the 320-bit state, in parallel.
- Sits between the constant-addition layer and the linear diffusion layer inside the Ascon round.
- Provides a zero-latency combinational output and a one-cycle registered copy with valid, for pipelined round datapaths.

Parameters:
- None in the module. Widths come from ascon_pkg: WORD_WIDTH = 64 (bits per word), NUM_WORDS = 5 (state words).

Ports:
- clk  input  1  rising-edge clock; used only by the registered path.
- rst_n  input  1  asynchronous active-low reset.
- state_array_i  input  ascon_state_t (5x64)  input state. Word i is S_i; element [i][j] is bit j of S_i.
- valid_i  input  1  qualifies state_array_i for the registered path.
- state_array_o  output  ascon_state_t  combinational S-box result of state_array_i.
- state_q_o  output  ascon_state_t  registered copy of state_array_o.
- valid_o  output  1  registered valid_i.

Behaviour:
- For every column j in 0..63, set x0..x4 = state_array_i[0..4][j]. Compute:
  - y0 = x4x1 ^ x3 ^ x2x1 ^ x2 ^ x1x0 ^ x1 ^ x0
  - y1 = x4 ^ x3x2 ^ x3x1 ^ x3 ^ x2x1 ^ x2 ^ x1 ^ x0
  - y2 = x4x3 ^ x4 ^ x2 ^ x1 ^ 1
  - y3 = x4x0 ^ x4 ^ x3x0 ^ x3 ^ x2 ^ x1 ^ x0
  - y4 = x4x1 ^ x4 ^ x3 ^ x1x0 ^ x1
- Write state_array_o[i][j] = yi.
- Equivalent lookup: index {x0,x1,x2,x3,x4} (x0 is the MSB) maps to {y0..y4} via 4,11,31,20,26,21,9,2,27,5,8,18,29,3,6,28,30,19,7,14,0,13,17,24,16,12,1,25,22,10,15,23.
- Columns are fully independent; there is no cross-column dependency.
- state_array_o is purely combinational with zero latency. It does not depend on clk, rst_n or valid_i. Output must be X-free whenever the input is X-free.
- Registered path, on the rising clk edge:
  - valid_o <= valid_i.
  - If valid_i is high, state_q_o <= state_array_o. If valid_i is low, state_q_o holds.
- Reset: when rst_n is low, asynchronously force state_q_o = 0 and valid_o = 0.
- Releasing reset mid-stream: the first capture happens on the first edge with valid_i high.
- There is no backpressure; a new input is accepted every cycle.

Optional Feature:
- Macro: ASCON_SBOX_LUT_EN.
- Defined: each column's S-box is implemented as the 32-entry constant lookup table above.
- Undefined: each column uses the boolean equations above.
- Port-level results are bit-identical in both builds.

Decomposition:
- ascon_pkg holds WORD_WIDTH, NUM_WORDS and ascon_state_t (packed [NUM_WORDS-1:0][WORD_WIDTH-1:0]).
- Add the 32-entry S-box table constant to ascon_pkg.
- Natural sub-module: ascon_sbox5 (5-bit in {x0..x4}, 5-bit out {y0..y4}), instantiated WORD_WIDTH times in a generate loop.

Test Plan:
- Truth-table sweep at column 0, all other bits 0, x = 0..31 with x0 = MSB:
  - Column 0 of the output must equal the table entry.
  - Every other column must equal the x = 0 image: only S2 bit = 1.
- All-zero state -> S0=0, S1=0, S2=FFFFFFFFFFFFFFFF, S3=0, S4=0.
- All-ones state -> S0=FFFFFFFFFFFFFFFF, S1=0, S2=S3=S4=FFFFFFFFFFFFFFFF.
- Only S4 = FFFFFFFFFFFFFFFF, rest 0 (x = 1 -> 11) -> S0=0, S1=all-ones, S2=0, S3=all-ones, S4=all-ones.
- 500 random states -> state_array_o matches the equation model bit-for-bit in both macro builds.
- Registered path:
  - Assert rst_n low mid-run -> state_q_o = 0 and valid_o = 0 immediately.
  - After release, valid_i=1 with the all-zero state -> one cycle later valid_o=1 and state_q_o S2 = all-ones.
  - valid_i=0 -> state_q_o holds its value.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared Ascon state types and the 5-bit S-box lookup table.
// The table is used by ascon_sbox5 when ASCON_SBOX_LUT_EN is defined.
package ascon_pkg;

    localparam int unsigned WORD_WIDTH = 64;
    localparam int unsigned NUM_WORDS  = 5;
    localparam int unsigned SBOX_WIDTH = 5;
    localparam int unsigned SBOX_DEPTH = 32;

    // Word i is S_i; [i][j] is bit j of S_i.
    typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] ascon_state_t;

    typedef logic [SBOX_WIDTH-1:0] sbox_word_t;

    // Indexed by {x0,x1,x2,x3,x4} with x0 as MSB; entries are {y0,y1,y2,y3,y4}.
    localparam sbox_word_t SBOX_TABLE [SBOX_DEPTH] = '{
        5'd4,  5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9,  5'd2,
        5'd27, 5'd5,  5'd8,  5'd18, 5'd29, 5'd3,  5'd6,  5'd28,
        5'd30, 5'd19, 5'd7,  5'd14, 5'd0,  5'd13, 5'd17, 5'd24,
        5'd16, 5'd12, 5'd1,  5'd25, 5'd22, 5'd10, 5'd15, 5'd23
    };

endpackage

// File: rtl/ascon_sbox5.sv
// Single-column Ascon 5-bit S-box, {x0..x4} in, {y0..y4} out (bit 4 is x0/y0).
// ASCON_SBOX_LUT_EN selects the constant table instead of the boolean equations.
module ascon_sbox5
    import ascon_pkg::*;
(
    input  logic [4:0] x,
    output logic [4:0] y
);

`ifdef ASCON_SBOX_LUT_EN

    assign y = SBOX_TABLE[x];

`else

    logic x0, x1, x2, x3, x4;
    logic y0, y1, y2, y3, y4;

    assign x0 = x[4];
    assign x1 = x[3];
    assign x2 = x[2];
    assign x3 = x[1];
    assign x4 = x[0];

    always_comb begin
        y0 = (x4 & x1) ^ x3 ^ (x2 & x1) ^ x2 ^ (x1 & x0) ^ x1 ^ x0;
        y1 = x4 ^ (x3 & x2) ^ (x3 & x1) ^ x3 ^ (x2 & x1) ^ x2 ^ x1 ^ x0;
        y2 = (x4 & x3) ^ x4 ^ x2 ^ x1 ^ 1'b1;
        y3 = (x4 & x0) ^ x4 ^ (x3 & x0) ^ x3 ^ x2 ^ x1 ^ x0;
        y4 = (x4 & x1) ^ x4 ^ x3 ^ (x1 & x0) ^ x1;
    end

    assign y = {y0, y1, y2, y3, y4};

`endif

endmodule

// File: rtl/substitution_layer.sv
// Ascon substitution layer p_S: 64 parallel S-boxes plus a one-cycle registered copy.
// Build option ASCON_SBOX_LUT_EN switches each S-box to the lookup-table form.
module substitution_layer
    import ascon_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  ascon_state_t state_array_i,
    input  logic         valid_i,
    output ascon_state_t state_array_o,
    output ascon_state_t state_q_o,
    output logic         valid_o
);

    ascon_state_t state_comb;

    for (genvar j = 0; j < WORD_WIDTH; j++) begin : g_col
        logic [4:0] col_in;
        logic [4:0] col_out;

        assign col_in = {state_array_i[0][j], state_array_i[1][j], state_array_i[2][j],
                         state_array_i[3][j], state_array_i[4][j]};

        ascon_sbox5 u_sbox (
            .x (col_in),
            .y (col_out)
        );

        assign state_comb[0][j] = col_out[4];
        assign state_comb[1][j] = col_out[3];
        assign state_comb[2][j] = col_out[2];
        assign state_comb[3][j] = col_out[1];
        assign state_comb[4][j] = col_out[0];
    end

    assign state_array_o = state_comb;

    ascon_state_t state_q;
    logic         valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                state_q <= state_comb;
            end
        end
    end

    assign state_q_o = state_q;
    assign valid_o   = valid_q;

endmodule

// File: tb/tb_substitution_layer.sv
// Randomised scoreboard bench for substitution_layer against an equation/table model.
module tb_substitution_layer;
    import ascon_pkg::*;

    logic         clk;
    logic         rst_n;
    ascon_state_t state_in;
    logic         valid_in;
    ascon_state_t state_comb;
    ascon_state_t state_q;
    logic         valid_out;

    int n_checks = 0;
    int n_fail   = 0;

    ascon_state_t exp_q[$];
    ascon_state_t last_cap;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    // Independent copy of the published S-box table.
    int ref_tbl [32] = '{4, 11, 31, 20, 26, 21, 9, 2, 27, 5, 8, 18, 29, 3, 6, 28,
                         30, 19, 7, 14, 0, 13, 17, 24, 16, 12, 1, 25, 22, 10, 15, 23};

    substitution_layer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .state_array_i (state_in),
        .valid_i       (valid_in),
        .state_array_o (state_comb),
        .state_q_o     (state_q),
        .valid_o       (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ascon_state_t ref_layer(input ascon_state_t s);
        ascon_state_t r;
        logic x0, x1, x2, x3, x4;
        for (int j = 0; j < 64; j++) begin
            x0 = s[0][j]; x1 = s[1][j]; x2 = s[2][j]; x3 = s[3][j]; x4 = s[4][j];
            r[0][j] = (x4 & x1) ^ x3 ^ (x2 & x1) ^ x2 ^ (x1 & x0) ^ x1 ^ x0;
            r[1][j] = x4 ^ (x3 & x2) ^ (x3 & x1) ^ x3 ^ (x2 & x1) ^ x2 ^ x1 ^ x0;
            r[2][j] = (x4 & x3) ^ x4 ^ x2 ^ x1 ^ 1'b1;
            r[3][j] = (x4 & x0) ^ x4 ^ (x3 & x0) ^ x3 ^ x2 ^ x1 ^ x0;
            r[4][j] = (x4 & x1) ^ x4 ^ x3 ^ (x1 & x0) ^ x1;
        end
        return r;
    endfunction

    task automatic check_state(input string name, input ascon_state_t act,
                               input ascon_state_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one input at the falling edge, check the combinational result, queue the capture.
    task automatic drive(input ascon_state_t s, input logic v, input ascon_state_t exp,
                         input string name);
        @(negedge clk);
        state_in = s;
        valid_in = v;
        #1;
        check_state(name, state_comb, exp);
        if (v) begin
            exp_q.push_back(exp);
            last_cap = exp;
        end
    endtask

    // Monitor: every presented registered output is matched against the queue head.
    always @(posedge clk) begin
        #1;
        if (rst_n && valid_out) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL q_unexpected: valid_o high with no pending entry, q=%h", state_q);
            end else begin
                ascon_state_t e;
                e = exp_q.pop_front();
                if (state_q !== e) begin
                    n_fail++;
                    $display("FAIL q_data: got %h expected %h", state_q, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        ascon_state_t s, e, zimg;
        int y;

        rst_n    = 1'b0;
        valid_in = 1'b0;
        state_in = '0;
        last_cap = '0;
        #3;
        check_state("reset_q", state_q, '0);
        check_bit("reset_valid", valid_out, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        zimg = '0;
        zimg[2] = ONES;

        // Truth-table sweep on column 0.
        for (int idx = 0; idx < 32; idx++) begin
            s = '0;
            for (int i = 0; i < 5; i++) s[i][0] = idx[4-i];
            e = zimg;
            y = ref_tbl[idx];
            for (int i = 0; i < 5; i++) e[i][0] = y[4-i];
            drive(s, 1'b1, e, $sformatf("sweep_%0d", idx));
        end

        s = '0;
        e = '0; e[2] = ONES;
        drive(s, 1'b1, e, "all_zero");

        s = {5{ONES}};
        e = '0; e[0] = ONES; e[2] = ONES; e[3] = ONES; e[4] = ONES;
        drive(s, 1'b1, e, "all_ones");

        s = '0; s[4] = ONES;
        e = '0; e[1] = ONES; e[3] = ONES; e[4] = ONES;
        drive(s, 1'b1, e, "only_s4");

        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < 5; i++) s[i] = {$urandom(), $urandom()};
            drive(s, 1'($urandom_range(0, 3) != 0), ref_layer(s), "random");
        end

        // Hold: valid low keeps the last capture.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) s[i] = {$urandom(), $urandom()};
            drive(s, 1'b0, ref_layer(s), "hold_comb");
            @(posedge clk);
            #1;
            check_state("hold_q", state_q, last_cap);
            check_bit("hold_valid", valid_out, 1'b0);
        end

        // Mid-run reset right after a capture.
        s = {5{ONES}};
        drive(s, 1'b1, ref_layer(s), "pre_reset");
        @(negedge clk);
        valid_in = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_state("midreset_q", state_q, '0);
        check_bit("midreset_valid", valid_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        s = '0;
        e = '0; e[2] = ONES;
        drive(s, 1'b1, e, "post_reset_zero");
        drive(s, 1'b0, e, "post_reset_idle");
        check_state("post_reset_q", state_q, e);
        check_bit("post_reset_valid", valid_out, 1'b1);
        @(posedge clk);
        #1;
        check_state("post_reset_hold", state_q, e);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
